// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and the
// default bit timing used by both the transmitter and the receiver.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    // Half a bit period in clock cycles; a full bit is twice this.
    localparam int unsigned UART_CLK_PER_HALF_BIT = 5208;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable
// reset value so idle-high and idle-low lines both come out of reset quietly.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a start-bit edge, held output byte
// with acknowledge handshake, framing-error pulse and sticky overrun flag.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER_HALF_BIT = UART_CLK_PER_HALF_BIT
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      rxd,
    input  logic                      rx_ack,
    output logic [UART_DATA_BITS-1:0] rdata,
    output logic                      rx_valid,
    output logic                      ferr,
    output logic                      overrun,
    output logic                      rx_busy
);

    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [31:0] HALF_END = 32'(CLK_PER_HALF_BIT - 1);
    localparam logic [31:0] FULL_END = 32'(2 * CLK_PER_HALF_BIT - 1);

    uart_rx_state_t            state;
    uart_rx_state_t            state_next;
    logic                      rxd_s;
    logic                      rxd_d;
    logic                      fall;
    logic [31:0]               counter;
    logic [IDX_W-1:0]          bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      counter_clear;
    logic                      shift_en;
    logic                      stop_good;
    logic                      stop_bad;

    sync_2ff #(
        .RESET_VALUE(1'b1)
    ) u_rxd_sync (
        .clock(clock),
        .reset(reset),
        .d    (rxd),
        .q    (rxd_s)
    );

    assign fall = rxd_d & ~rxd_s;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        counter_clear = 1'b0;
        shift_en      = 1'b0;
        stop_good     = 1'b0;
        stop_bad      = 1'b0;
        case (state)
            IDLE: begin
                counter_clear = 1'b1;
                if (fall) begin
                    state_next = START;
                end
            end
            START: begin
                // A start bit that is high again at its midpoint was a glitch.
                if (counter == HALF_END) begin
                    counter_clear = 1'b1;
                    state_next    = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (counter == FULL_END) begin
                    counter_clear = 1'b1;
                    shift_en      = 1'b1;
                    if (bit_idx == IDX_W'(UART_DATA_BITS - 1)) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                // Leaving at mid stop bit lets a back-to-back start edge be seen.
                if (counter == FULL_END) begin
                    counter_clear = 1'b1;
                    stop_good     = rxd_s;
                    stop_bad      = ~rxd_s;
                    state_next    = rxd_s ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                counter_clear = 1'b1;
                if (rxd_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                counter_clear = 1'b1;
                state_next    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rxd_d    <= 1'b1;
            counter  <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            rdata    <= '0;
            rx_valid <= 1'b0;
            ferr     <= 1'b0;
            overrun  <= 1'b0;
            rx_busy  <= 1'b0;
        end else begin
            rxd_d   <= rxd_s;
            counter <= counter_clear ? '0 : counter + 32'd1;
            rx_busy <= (state_next != IDLE);
            ferr    <= stop_bad;

            if (state == START) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + IDX_W'(1);
            end

            if (shift_en) begin
                shreg <= {rxd_s, shreg[UART_DATA_BITS-1:1]};
            end

            // An acknowledge in the same cycle frees the holding register.
            if (stop_good && (!rx_valid || rx_ack)) begin
                rdata    <= shreg;
                rx_valid <= 1'b1;
            end else begin
                if (stop_good) begin
                    overrun <= 1'b1;
                end
                if (rx_valid && rx_ack) begin
                    rx_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frames are driven bit by bit on rxd, expected bytes and
// framing errors go into a queue, and a monitor matches them as they appear.
module tb_uart_rx;

    localparam int H         = 4;
    localparam int BIT       = 2 * H;
    localparam int STOP_EDGE = 3 + (H - 1) + 9 * 2 * H + 1;

    typedef struct {
        bit         is_ferr;
        logic [7:0] data;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       rxd;
    logic       rx_ack;
    logic [7:0] rdata;
    logic       rx_valid;
    logic       ferr;
    logic       overrun;
    logic       rx_busy;

    int   tests_run     = 0;
    int   tests_failed  = 0;
    int   edge_count    = 0;
    int   force_edge    = -1;
    bit   auto_ack      = 1'b0;
    bit   model_pending = 1'b0;
    bit   model_overrun = 1'b0;
    bit   prev_valid    = 1'b0;
    exp_t exp_q[$];

    uart_rx #(
        .CLK_PER_HALF_BIT(H)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .rxd     (rxd),
        .rx_ack  (rx_ack),
        .rdata   (rdata),
        .rx_valid(rx_valid),
        .ferr    (ferr),
        .overrun (overrun),
        .rx_busy (rx_busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) edge_count <= edge_count + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic popCheck(input bit is_ferr, input logic [7:0] data);
        exp_t e;
        if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL unexpected_event: actual ferr=%0b data=0x%0h required=no event", is_ferr, data);
        end else begin
            e = exp_q.pop_front();
            checkOutput(is_ferr ? "ferr_event" : "byte_event", {23'd0, is_ferr, data}, {23'd0, e.is_ferr, e.data});
        end
    endtask

    // Consumer: a forced acknowledge at a chosen edge, or an automatic one.
    initial begin
        rx_ack = 1'b0;
        forever begin
            @(negedge clock);
            if (edge_count + 1 == force_edge) rx_ack = 1'b1;
            else if (auto_ack && rx_valid && !rx_ack) rx_ack = 1'b1;
            else rx_ack = 1'b0;
        end
    end

    // Monitor: a new byte is presented when valid rises or survives an ack.
    always @(posedge clock) begin
        #1;
        if (!reset) begin
            if (ferr) popCheck(1'b1, 8'h00);
            if (rx_valid && (!prev_valid || rx_ack)) popCheck(1'b0, rdata);
        end
        prev_valid = rx_valid;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic waitEdge(input int target);
        while (1) begin
            @(posedge clock);
            #1;
            if (edge_count >= target) break;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic driveFrame(input logic [7:0] d, input bit stop_good);
        rxd = 1'b0;
        idle(BIT);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            idle(BIT);
        end
        rxd = stop_good;
        idle(BIT);
    endtask

    task automatic applyStimulus(input logic [7:0] d, input bit stop_good, input bit ack_at_stop);
        if (ack_at_stop) force_edge = edge_count + STOP_EDGE;
        if (stop_good) begin
            if (model_pending && !ack_at_stop) begin
                model_overrun = 1'b1;
            end else begin
                exp_q.push_back('{1'b0, d});
                model_pending = !auto_ack;
            end
        end else begin
            exp_q.push_back('{1'b1, 8'h00});
        end
        driveFrame(d, stop_good);
    endtask

    initial begin
        int         s;
        logic [7:0] d;
        bit         good;
        logic [7:0] loop_bytes [4] = '{8'h00, 8'hFF, 8'h55, 8'h80};

        reset = 1'b1;
        rxd   = 1'b1;
        idle(3);
        checkOutput("reset_rdata", rdata, 0);
        checkOutput("reset_valid", rx_valid, 0);
        checkOutput("reset_ferr", ferr, 0);
        checkOutput("reset_overrun", overrun, 0);
        checkOutput("reset_busy", rx_busy, 0);
        reset = 1'b0;
        idle(4);

        // Good byte with exact output timing, then a manual acknowledge.
        s = edge_count;
        fork
            applyStimulus(8'hA5, 1'b1, 1'b0);
            begin
                waitEdge(s + STOP_EDGE - 1);
                checkOutput("valid_before_stop", rx_valid, 0);
                waitEdge(s + STOP_EDGE);
                checkOutput("valid_after_stop", rx_valid, 1);
                checkOutput("rdata_a5", rdata, 8'hA5);
                checkOutput("ferr_good_frame", ferr, 0);
            end
        join
        force_edge = edge_count + 2;
        waitEdge(force_edge);
        checkOutput("valid_after_ack", rx_valid, 0);
        model_pending = 1'b0;
        @(negedge clock);
        auto_ack = 1'b1;
        idle(4);

        // Glitch shorter than half a bit.
        s   = edge_count;
        rxd = 1'b0;
        idle(2);
        rxd = 1'b1;
        waitEdge(s + 3);
        checkOutput("glitch_busy", rx_busy, 1);
        @(negedge clock);
        idle(12);
        checkOutput("glitch_idle", rx_busy, 0);
        checkOutput("glitch_overrun", overrun, 0);

        // Framing error followed by a held-low line and a clean frame.
        applyStimulus(8'h3C, 1'b0, 1'b0);
        idle(20);
        checkOutput("wait_high_busy", rx_busy, 1);
        rxd = 1'b1;
        idle(BIT);
        checkOutput("wait_high_exit", rx_busy, 0);
        applyStimulus(8'h11, 1'b1, 1'b0);
        idle(BIT);

        // Overrun with no acknowledge.
        auto_ack = 1'b0;
        applyStimulus(8'h01, 1'b1, 1'b0);
        applyStimulus(8'h02, 1'b1, 1'b0);
        idle(4);
        checkOutput("overrun_rdata", rdata, 8'h01);
        checkOutput("overrun_valid", rx_valid, 1);
        checkOutput("overrun_flag", overrun, model_overrun);
        checkOutput("queue_empty_pre_reset", exp_q.size(), 0);
        reset = 1'b1;
        idle(2);
        reset         = 1'b0;
        model_pending = 1'b0;
        model_overrun = 1'b0;
        idle(2);

        // Acknowledge lands on the stop-sample edge of the second byte.
        applyStimulus(8'h01, 1'b1, 1'b0);
        applyStimulus(8'h02, 1'b1, 1'b1);
        idle(4);
        checkOutput("race_rdata", rdata, 8'h02);
        checkOutput("race_valid", rx_valid, 1);
        checkOutput("race_overrun", overrun, model_overrun);

        // Asynchronous reset in the middle of data bit 4.
        s = edge_count;
        fork
            driveFrame(8'hFF, 1'b1);
            begin
                waitEdge(s + 5 * BIT + H);
                checkOutput("busy_midframe", rx_busy, 1);
                #3;
                reset = 1'b1;
                #1;
                checkOutput("async_rdata", rdata, 0);
                checkOutput("async_valid", rx_valid, 0);
                checkOutput("async_ferr", ferr, 0);
                checkOutput("async_overrun", overrun, 0);
                checkOutput("async_busy", rx_busy, 0);
                idle(3);
                reset         = 1'b0;
                model_pending = 1'b0;
                model_overrun = 1'b0;
            end
        join
        auto_ack = 1'b1;
        idle(2);
        applyStimulus(8'h5A, 1'b1, 1'b0);
        idle(BIT);

        // Loopback-style back-to-back frames.
        for (int i = 0; i < 4; i++) applyStimulus(loop_bytes[i], 1'b1, 1'b0);
        idle(BIT);

        // Random frames with occasional framing errors and random gaps.
        repeat (24) begin
            d    = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 7) != 0);
            applyStimulus(d, good, 1'b0);
            if (!good) begin
                rxd = 1'b1;
                idle(BIT + $urandom_range(0, 8));
            end else begin
                idle($urandom_range(0, 3));
            end
        end

        idle(3 * BIT);
        checkOutput("queue_drained", exp_q.size(), 0);
        checkOutput("overrun_final", overrun, model_overrun);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
